// File: rtl/uart_receiver_if.sv
// uart_receiver_if: tick/serial inputs and byte/status outputs of uart_receiver.
// master = receiver side (drives o_*), slave = line/consumer side. Parity: UART_RX_PARITY_EN.
interface uart_receiver_if;
  logic       i_CLK_ENABLE;
  logic       i_RX;
  logic [7:0] o_DATA_OUT;
  logic       o_RX_VALID;
  logic       o_FRAME_ERROR;
  logic       o_RX_BUSY;
`ifdef UART_RX_PARITY_EN
  logic       o_PARITY_ERROR;

  modport master (
    input  i_CLK_ENABLE, i_RX,
    output o_DATA_OUT, o_RX_VALID,
    output o_FRAME_ERROR, o_RX_BUSY,
    output o_PARITY_ERROR
  );
  modport slave (
    output i_CLK_ENABLE, i_RX,
    input  o_DATA_OUT, o_RX_VALID,
    input  o_FRAME_ERROR, o_RX_BUSY,
    input  o_PARITY_ERROR
  );
`else
  modport master (
    input  i_CLK_ENABLE, i_RX,
    output o_DATA_OUT, o_RX_VALID,
    output o_FRAME_ERROR, o_RX_BUSY
  );
  modport slave (
    output i_CLK_ENABLE, i_RX,
    input  o_DATA_OUT, o_RX_VALID,
    input  o_FRAME_ERROR, o_RX_BUSY
  );
`endif
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver (8E1 with UART_RX_PARITY_EN).
// Ports: i_CLK, i_RESET (async high), bus (uart_receiver_if.master).
module uart_receiver (
  input logic      i_CLK,
  input logic      i_RESET,
  uart_receiver_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic       par_q, par_d;
  logic       perr_q, perr_d;
`endif
  logic       line;

  assign line = sync2_q;

  always_comb begin
    state_d = state_q;
    sync1_d = bus.i_RX;
    sync2_d = sync1_q;
    prev_d  = prev_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    if (bus.i_CLK_ENABLE) begin
      // prev tracks the line on ticks so a held-low
      // line (break) never looks like a start edge
      prev_d = line;
      unique case (state_q)
        IDLE: begin
          if (prev_q && !line) begin
            state_d = START;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
          end
        end
        START: begin
          if (tick_q == 4'd7) begin
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = line ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
        DATA: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {line, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            // even parity: total ones must be even
            par_d   = (^shift_q) ^ line;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            data_d  = shift_q;
            ferr_d  = ~line;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = par_q;
`endif
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      tick_q  <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.o_DATA_OUT    = data_q;
  assign bus.o_RX_VALID    = valid_q;
  assign bus.o_FRAME_ERROR = ferr_q;
  assign bus.o_RX_BUSY     = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_PARITY_ERROR = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed frames against a frame-level model.
// Tick every 4 clocks, 16 ticks per bit.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic rst;
  uart_receiver_if bus();

  uart_receiver dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_d;
  logic       last_fe;
  logic       last_pe;
  int         n_chk;
  int         n_pass;
  int         n_pulse;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  initial begin
    int c;
    c = 0;
    bus.i_CLK_ENABLE = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_CLK_ENABLE = (c % 4 == 0);
      c++;
    end
  end

  initial begin
    exp_t e;
    logic prev_v;
    prev_v  = 1'b0;
    last_d  = 8'd0;
    last_fe = 1'b0;
    last_pe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        last_d  = 8'd0;
        last_fe = 1'b0;
        last_pe = 1'b0;
        prev_v  = 1'b0;
        chk("rst_data", {24'd0, bus.o_DATA_OUT}, 0);
        chk("rst_valid", {31'd0, bus.o_RX_VALID}, 0);
        chk("rst_busy", {31'd0, bus.o_RX_BUSY}, 0);
      end else if (bus.o_RX_VALID) begin
        n_pulse++;
        chk("valid_width", {31'd0, prev_v}, 0);
        prev_v = 1'b1;
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pulse: got data %0h expected none",
                   bus.o_DATA_OUT);
        end else begin
          e = q.pop_front();
          last_d  = e.d;
          last_fe = e.fe;
          last_pe = e.pe;
          chk("frame_data", {24'd0, bus.o_DATA_OUT}, {24'd0, e.d});
          chk("frame_ferr", {31'd0, bus.o_FRAME_ERROR}, {31'd0, e.fe});
`ifdef UART_RX_PARITY_EN
          chk("frame_perr", {31'd0, bus.o_PARITY_ERROR}, {31'd0, e.pe});
`endif
        end
      end else begin
        prev_v = 1'b0;
        chk("hold_data", {24'd0, bus.o_DATA_OUT}, {24'd0, last_d});
        chk("hold_ferr", {31'd0, bus.o_FRAME_ERROR}, {31'd0, last_fe});
`ifdef UART_RX_PARITY_EN
        chk("hold_perr", {31'd0, bus.o_PARITY_ERROR}, {31'd0, last_pe});
`endif
      end
    end
  end

  task automatic bitp(logic b, int nt);
    bus.i_RX = b;
    repeat (nt * 4) @(posedge clk);
    #1;
  endtask

  task automatic frame(logic [7:0] d, logic stopb, logic pbit);
    exp_t e;
    e.d  = d;
    e.fe = ~stopb;
`ifdef UART_RX_PARITY_EN
    e.pe = (^d) ^ pbit;
`else
    e.pe = pbit & 1'b0;
`endif
    q.push_back(e);
    bitp(1'b0, 16);
    for (int i = 0; i < 8; i++) bitp(d[i], 16);
`ifdef UART_RX_PARITY_EN
    bitp(pbit, 16);
`endif
    bitp(stopb, 16);
    chk("pulse_seen", q.size(), 0);
  endtask

  initial begin
    int p0;
    int bcnt;
    logic [7:0] rb;
    logic sb;
    n_chk   = 0;
    n_pass  = 0;
    n_pulse = 0;
    bus.i_RX = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    bitp(1'b1, 20);

    p0 = n_pulse;
    frame(8'hA5, 1'b1, 1'b0);
    chk("a5_data", {24'd0, bus.o_DATA_OUT}, 32'hA5);
    chk("a5_ferr", {31'd0, bus.o_FRAME_ERROR}, 0);
    chk("a5_pulses", n_pulse - p0, 1);
    bitp(1'b1, 5);

    p0 = n_pulse;
    frame(8'h00, 1'b1, 1'b0);
    chk("b2b_first", {24'd0, bus.o_DATA_OUT}, 32'h00);
    frame(8'hFF, 1'b1, 1'b0);
    chk("b2b_second", {24'd0, bus.o_DATA_OUT}, 32'hFF);
    chk("b2b_pulses", n_pulse - p0, 2);
    bitp(1'b1, 16);

    p0 = n_pulse;
    bcnt = 0;
    bus.i_RX = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (bus.o_RX_BUSY) bcnt++;
    end
    bus.i_RX = 1'b1;
    repeat (64) begin
      @(posedge clk); #1;
      if (bus.o_RX_BUSY) bcnt++;
    end
    chk("glitch_busy_max", {31'd0, (bcnt <= 32)}, 1);
    chk("glitch_busy_seen", {31'd0, (bcnt > 0)}, 1);
    chk("glitch_no_pulse", n_pulse - p0, 0);
    chk("glitch_idle", {31'd0, bus.o_RX_BUSY}, 0);

    p0 = n_pulse;
    frame(8'h3C, 1'b0, 1'b0);
    chk("ferr_data", {24'd0, bus.o_DATA_OUT}, 32'h3C);
    chk("ferr_flag", {31'd0, bus.o_FRAME_ERROR}, 1);
    bitp(1'b0, 40);
    chk("break_no_frame", n_pulse - p0, 1);
    chk("break_idle", {31'd0, bus.o_RX_BUSY}, 0);
    bitp(1'b1, 16);

    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      sb = ($urandom % 5) != 0;
      frame(rb, sb, 1'($urandom));
      if (!sb) bitp(1'b1, 16);
      else bitp(1'b1, $urandom_range(0, 20));
    end

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0);
    chk("par07_p0", {31'd0, bus.o_PARITY_ERROR}, 1);
    frame(8'h07, 1'b1, 1'b1);
    chk("par07_p1", {31'd0, bus.o_PARITY_ERROR}, 0);
    bitp(1'b1, 4);
`endif

    frame(8'h5A, 1'b1, 1'b0);
    bitp(1'b1, 8);
    bitp(1'b0, 16);
    bitp(1'b1, 16);
    bitp(1'b0, 16);
    bitp(1'b1, 16);
    bitp(1'b0, 16);
    bus.i_RX = 1'b1;
    repeat (32) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_imm_data", {24'd0, bus.o_DATA_OUT}, 0);
    chk("rst_imm_ferr", {31'd0, bus.o_FRAME_ERROR}, 0);
    chk("rst_imm_busy", {31'd0, bus.o_RX_BUSY}, 0);
    chk("rst_imm_valid", {31'd0, bus.o_RX_VALID}, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bitp(1'b1, 16);
    chk("post_rst_idle", {31'd0, bus.o_RX_BUSY}, 0);
    p0 = n_pulse;
    frame(8'h81, 1'b1, 1'b0);
    chk("post_rst_data", {24'd0, bus.o_DATA_OUT}, 32'h81);
    chk("post_rst_pulses", n_pulse - p0, 1);
    bitp(1'b1, 16);

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
